train_seq_ctrl: RTL and testbench

Sequencer for one training run of the layer datapath. Per iteration it:
- accepts one sample;
- launches the layer on `x` (`use_z`=0);
- captures the layer result as `z` and the current `predict_value` as `predict_value_old`;
- relaunches the layer on the captured pair (`use_z`=1).

It drives the select of `train_data_mux` and owns the registers feeding the mux's `z` and `predict_value_old` inputs. It sits between the top-level training control and the layer compute engine.

---
 rtl/train_pkg.sv | 18 +
 rtl/train_seq_watchdog.sv | 30 +++
 rtl/train_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_train_seq_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/train_pkg.sv
// Shared types and default vector geometry for the training datapath
// (train_seq_ctrl and train_data_mux).
package train_pkg;

    localparam int DATA_SIZE = 16;
    localparam int SIZE      = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RUN_X,
        WAIT_X,
        RUN_Z,
        WAIT_Z,
        DONE
    } train_seq_state_t;

endpackage

// File: rtl/train_seq_watchdog.sv
// Per-pass watchdog: cleared by load, counts while enabled, and flags expire
// on the last permitted cycle so the FSM can leave on that same edge.
module train_seq_watchdog #(
    parameter int timeout_cycles = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(timeout_cycles - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (enable && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt == LIMIT);

endmodule

// File: rtl/train_seq_ctrl.sv
// Training-run sequencer: fetch sample, run layer on x, capture z/prediction,
// rerun on z. Optional layer watchdog enabled by TRAIN_SEQ_TIMEOUT_EN.
module train_seq_ctrl
    import train_pkg::*;
#(
    parameter int data_size      = DATA_SIZE,
    parameter int size           = SIZE,
    parameter int iter_w         = 8,
    parameter int timeout_cycles = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [iter_w-1:0]         num_iter,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      layer_start,
    input  logic                      layer_done,
    input  logic [data_size*size-1:0] layer_out,
    input  logic [data_size*size-1:0] predict_value,
    output logic                      use_z,
    output logic [data_size*size-1:0] z,
    output logic [data_size*size-1:0] predict_value_old,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    train_seq_state_t  state;
    logic [iter_w-1:0] num_iter_q;
    logic [iter_w-1:0] iter_cnt;
    logic [iter_w-1:0] iter_nxt;

    assign iter_nxt = iter_cnt + 1'b1;

`ifdef TRAIN_SEQ_TIMEOUT_EN
    logic wd_expire;
    logic error_q;

    train_seq_watchdog #(.timeout_cycles(timeout_cycles)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (state == RUN_X || state == RUN_Z),
        .enable (state == WAIT_X || state == WAIT_Z),
        .expire (wd_expire)
    );

    assign error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (timeout_cycles == 0);
    assign error = 1'b0;
`endif

    // Outputs are registered alongside the state so each reflects the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            num_iter_q        <= '0;
            iter_cnt          <= '0;
            z                 <= '0;
            predict_value_old <= '0;
            use_z             <= 1'b0;
            layer_start       <= 1'b0;
            sample_ready      <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
`ifdef TRAIN_SEQ_TIMEOUT_EN
            error_q           <= 1'b0;
`endif
        end else begin
            layer_start <= 1'b0;
            done        <= 1'b0;
`ifdef TRAIN_SEQ_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        num_iter_q <= num_iter;
                        iter_cnt   <= '0;
                        busy       <= 1'b1;
                        if (num_iter == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            sample_ready <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (sample_valid) begin
                        state        <= RUN_X;
                        sample_ready <= 1'b0;
                        layer_start  <= 1'b1;
                        use_z        <= 1'b0;
                    end
                end
                RUN_X: state <= WAIT_X;
                WAIT_X: begin
                    if (layer_done) begin
                        z                 <= layer_out;
                        predict_value_old <= predict_value;
                        state             <= RUN_Z;
                        layer_start       <= 1'b1;
                        use_z             <= 1'b1;
                    end
`ifdef TRAIN_SEQ_TIMEOUT_EN
                    else if (wd_expire) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        error_q <= 1'b1;
                    end
`endif
                end
                RUN_Z: state <= WAIT_Z;
                WAIT_Z: begin
                    if (layer_done) begin
                        iter_cnt <= iter_nxt;
                        use_z    <= 1'b0;
                        if (iter_nxt == num_iter_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            sample_ready <= 1'b1;
                        end
                    end
`ifdef TRAIN_SEQ_TIMEOUT_EN
                    else if (wd_expire) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        error_q <= 1'b1;
                        use_z   <= 1'b0;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_train_seq_ctrl.sv
// Scoreboard bench for train_seq_ctrl: stimulus pushes expected layer_start /
// done events; a monitor pops and checks them as the DUT produces them.
module tb_train_seq_ctrl;

    localparam int DS = 16;
    localparam int SZ = 3;
    localparam int IW = 8;
    localparam int W  = DS * SZ;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] num_iter;
    logic          sample_valid;
    logic          sample_ready;
    logic          layer_start;
    logic          layer_done;
    logic [W-1:0]  layer_out;
    logic [W-1:0]  predict_value;
    logic          use_z;
    logic [W-1:0]  z;
    logic [W-1:0]  predict_value_old;
    logic          busy;
    logic          done;
    logic          error;

    train_seq_ctrl #(
        .data_size(DS), .size(SZ), .iter_w(IW), .timeout_cycles(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_iter(num_iter),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .layer_start(layer_start), .layer_done(layer_done),
        .layer_out(layer_out), .predict_value(predict_value),
        .use_z(use_z), .z(z), .predict_value_old(predict_value_old),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_done;
        bit           uz;
        bit           err;
        logic [W-1:0] z;
        logic [W-1:0] pvo;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ls_cnt  = 0;

    // Layer engine model: answers one cycle after each layer_start.
    logic ld_auto  = 1'b0;
    logic prev_ls  = 1'b0;
    logic auto_resp = 1'b1;
    logic force_ld = 1'b0;
    assign layer_done = ld_auto | force_ld;

    always @(negedge clk) begin
        if (reset) begin
            ld_auto = 1'b0;
            prev_ls = 1'b0;
        end else begin
            ld_auto = auto_resp && prev_ls;
            prev_ls = layer_start;
        end
    end

    function automatic exp_t mk(bit d, bit uz, bit er, logic [W-1:0] zz, logic [W-1:0] pp);
        exp_t e;
        e.is_done = d; e.uz = uz; e.err = er; e.z = zz; e.pvo = pp;
        return e;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (layer_start) begin
                ls_cnt++;
                if (q.size() == 0) fail_now("unexpected layer_start");
                else begin
                    e = q.pop_front();
                    n_tests++;
                    if (e.is_done) begin
                        n_fail++;
                        $display("FAIL order: got layer_start expected done");
                    end
                    chk("ls_use_z", use_z, e.uz);
                end
            end
            if (done) begin
                if (q.size() == 0) fail_now("unexpected done");
                else begin
                    e = q.pop_front();
                    n_tests++;
                    if (!e.is_done) begin
                        n_fail++;
                        $display("FAIL order: got done expected layer_start");
                    end
                    chk("done_z", z, e.z);
                    chk("done_pvo", predict_value_old, e.pvo);
                    chk("done_error", error, e.err);
                end
            end
            if (error && !done) fail_now("error without done");
        end
    end

    task automatic kick(int n);
        num_iter = IW'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_iter = 8'hA5;
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!sample_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!sample_ready) fail_now("wait_ready timeout");
    endtask

    task automatic do_sample(int dly, logic [W-1:0] lo, logic [W-1:0] pv);
        wait_ready();
        q.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0));
        q.push_back(mk(1'b0, 1'b1, 1'b0, '0, '0));
        for (int i = 0; i < dly; i++) begin
            chk("ready_held", sample_ready, 1);
            @(negedge clk);
        end
        chk("ready_at_hs", sample_ready, 1);
        layer_out = lo;
        predict_value = pv;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (busy) fail_now("wait_idle timeout");
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_z"}, z, 0);
        chk({tag, "_pvo"}, predict_value_old, 0);
        chk({tag, "_use_z"}, use_z, 0);
        chk({tag, "_layer_start"}, layer_start, 0);
        chk({tag, "_sample_ready"}, sample_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ls0, b, r, c;
        logic [W-1:0] lz, lp;
        reset = 1'b1; start = 1'b0; num_iter = '0; sample_valid = 1'b0;
        layer_out = '0; predict_value = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single iteration
        ls0 = ls_cnt;
        kick(1);
        chk("single_busy", busy, 1);
        do_sample(0, 48'h0001_0002_0003, 48'h000A_000B_000C);
        q.push_back(mk(1'b1, 1'b0, 1'b0, 48'h0001_0002_0003, 48'h000A_000B_000C));
        wait_idle();
        chk("single_ls_count", ls_cnt - ls0, 2);
        chk("single_z_hold", z, 48'h0001_0002_0003);

        // Three iterations with 4-cycle sample stalls
        ls0 = ls_cnt;
        kick(3);
        do_sample(4, 48'h1111_2222_3333, 48'h4444_5555_6666);
        do_sample(4, 48'h7777_8888_9999, 48'hAAAA_BBBB_CCCC);
        do_sample(4, 48'h0123_4567_89AB, 48'hCDEF_0011_2233);
        q.push_back(mk(1'b1, 1'b0, 1'b0, 48'h0123_4567_89AB, 48'hCDEF_0011_2233));
        wait_idle();
        chk("three_ls_count", ls_cnt - ls0, 6);

        // Zero iterations: captured values persist
        ls0 = ls_cnt;
        q.push_back(mk(1'b1, 1'b0, 1'b0, 48'h0123_4567_89AB, 48'hCDEF_0011_2233));
        kick(0);
        b = 0; r = 0;
        for (int i = 0; i < 5; i++) begin
            b += int'(busy);
            r += int'(sample_ready);
            @(negedge clk);
        end
        chk("zero_busy_cycles", b, 1);
        chk("zero_sample_ready", r, 0);
        chk("zero_ls_count", ls_cnt - ls0, 0);

        // Ignored inputs: layer_done in FETCH, start + num_iter change in WAIT_X
        ls0 = ls_cnt;
        kick(2);
        wait_ready();
        force_ld = 1'b1;
        @(negedge clk);
        force_ld = 1'b0;
        chk("ign_ready_after_ld", sample_ready, 1);
        chk("ign_ls_after_ld", layer_start, 0);
        q.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0));
        q.push_back(mk(1'b0, 1'b1, 1'b0, '0, '0));
        layer_out = 48'h00AA_00BB_00CC;
        predict_value = 48'h00DD_00EE_00FF;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("ign_wait_x_use_z", use_z, 0);
        num_iter = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_sample(1, 48'h0F0F_F0F0_5555, 48'hAAAA_0000_FFFF);
        q.push_back(mk(1'b1, 1'b0, 1'b0, 48'h0F0F_F0F0_5555, 48'hAAAA_0000_FFFF));
        wait_idle();
        chk("ign_ls_count", ls_cnt - ls0, 4);

        // Reset during WAIT_Z of iteration 1 of 3
        kick(3);
        do_sample(0, 48'h1234_5678_9ABC, 48'hDEF0_1357_2468);
        c = 0;
        while (!(use_z && !layer_start) && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("rst_reached_wait_z", use_z && !layer_start, 1);
        reset = 1'b1;
        #1;
        chk_zero_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_queue_empty", q.size(), 0);
        ls0 = ls_cnt;
        kick(1);
        do_sample(0, 48'hCAFE_BEEF_0042, 48'h0BAD_F00D_0007);
        q.push_back(mk(1'b1, 1'b0, 1'b0, 48'hCAFE_BEEF_0042, 48'h0BAD_F00D_0007));
        wait_idle();
        chk("midrst_rerun_ls", ls_cnt - ls0, 2);

`ifdef TRAIN_SEQ_TIMEOUT_EN
        // Watchdog: no layer_done in WAIT_X
        lz = z; lp = predict_value_old;
        auto_resp = 1'b0;
        kick(1);
        wait_ready();
        q.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0));
        q.push_back(mk(1'b1, 1'b0, 1'b1, lz, lp));
        layer_out = 48'hFFFF_FFFF_FFFF;
        predict_value = 48'hEEEE_EEEE_EEEE;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        c = 0;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_latency", c, 17);
        @(negedge clk);
        chk("timeout_idle", busy, 0);
        auto_resp = 1'b1;
        wait_idle();
`else
        lz = z; lp = predict_value_old;
        chk("final_z_hold", lz, 48'hCAFE_BEEF_0042);
        chk("final_pvo_hold", lp, 48'h0BAD_F00D_0007);
`endif

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
